// File: rtl/bfis_query_sequencer.sv
// rtl/bfis_query_sequencer.sv - sequences one k-NN query: clears bfis, streams vertices, returns top-k.
// Optional watchdog on the result wait: define SEQ_WATCHDOG_EN.
module bfis_query_sequencer #(
  parameter int DIM            = 4,
  parameter int WIDTH          = 16,
  parameter int PQ_LENGTH      = 8,
  parameter int NUM_VERTICES   = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = $clog2(NUM_VERTICES)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       req_valid_in,
  output logic                       req_ready_out,
  input  logic [DIM*WIDTH-1:0]       req_query_in,
  input  logic [3:0]                 req_k_in,
  input  logic [ADDR_W:0]            req_nverts_in,
  output logic                       mem_rd_en_out,
  output logic [ADDR_W-1:0]          mem_addr_out,
  input  logic [DIM*WIDTH-1:0]       mem_data_in,
  output logic                       bfis_rst_out,
  output logic [DIM*WIDTH-1:0]       bfis_vertex_out,
  output logic                       bfis_vertex_valid_out,
  output logic [DIM*WIDTH-1:0]       bfis_query_out,
  output logic [3:0]                 bfis_k_out,
  input  logic                       bfis_valid_in,
  input  logic [PQ_LENGTH*WIDTH-1:0] bfis_top_k_in,
  output logic                       res_valid_out,
  input  logic                       res_ready_in,
  output logic [PQ_LENGTH*WIDTH-1:0] res_top_k_out,
  output logic                       res_timeout_out,
  output logic                       busy_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_WAIT, S_DONE
  } state_t;

  state_t                     state, state_nxt;
  logic [DIM*WIDTH-1:0]       query_q;
  logic [3:0]                 k_q;
  logic [ADDR_W:0]            nverts_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [PQ_LENGTH*WIDTH-1:0] res_q;
  logic                       vvalid_q;
  logic                       accept;
  logic                       last_addr;
  logic                       capture;
  logic                       wd_fire;
  logic [3:0]                 k_clamped;
  logic [ADDR_W:0]            nv_clamped;

  // Ready is gated by reset so every output reads zero while rst_in is high.
  assign req_ready_out = (state == S_IDLE) && !rst_in;
  assign accept        = req_valid_in && req_ready_out;
  assign last_addr     = ({1'b0, addr_q} == (nverts_q - (ADDR_W+1)'(1)));
  assign capture       = (state == S_WAIT) && bfis_valid_in;

  always_comb begin
    k_clamped  = req_k_in;
    nv_clamped = req_nverts_in;
    if (req_k_in == 4'd0)
      k_clamped = 4'd1;
    else if (int'(req_k_in) > PQ_LENGTH)
      k_clamped = 4'(PQ_LENGTH);
    if (int'(req_nverts_in) > NUM_VERTICES)
      nv_clamped = (ADDR_W+1)'(NUM_VERTICES);
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt_q;
  logic             timeout_q;

  assign wd_fire = (state == S_WAIT) && !bfis_valid_in
                   && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q <= (state == S_WAIT) ? wd_cnt_q + CNT_W'(1) : '0;
      if (wd_fire)
        timeout_q <= 1'b1;
      else if (state == S_DONE && res_ready_in)
        timeout_q <= 1'b0;
    end
  end

  assign res_timeout_out = timeout_q;
`else
  logic unused_wd_cfg;
  assign unused_wd_cfg   = (TIMEOUT_CYCLES == 0);
  assign wd_fire         = 1'b0;
  assign res_timeout_out = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = (req_nverts_in == '0) ? S_DONE : S_CLEAR;
      S_CLEAR:  state_nxt = S_STREAM;
      S_STREAM: if (last_addr) state_nxt = S_DRAIN;
      S_DRAIN:  state_nxt = S_WAIT;
      S_WAIT:   if (capture || wd_fire) state_nxt = S_DONE;
      S_DONE:   if (res_ready_in) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      query_q  <= '0;
      k_q      <= '0;
      nverts_q <= '0;
      addr_q   <= '0;
      res_q    <= '0;
      vvalid_q <= 1'b0;
    end else begin
      vvalid_q <= (state == S_STREAM);
      addr_q   <= (state == S_STREAM && !last_addr) ? addr_q + ADDR_W'(1) : '0;
      if (accept) begin
        query_q  <= req_query_in;
        k_q      <= k_clamped;
        nverts_q <= nv_clamped;
        if (req_nverts_in == '0)
          res_q <= '0;
      end
      if (capture)
        res_q <= bfis_top_k_in;
      else if (wd_fire)
        res_q <= '0;
    end
  end

  assign mem_rd_en_out         = (state == S_STREAM);
  assign mem_addr_out          = addr_q;
  assign bfis_rst_out          = (state == S_CLEAR);
  // Memory data arrives one cycle after the strobe, aligned with vvalid_q.
  assign bfis_vertex_valid_out = vvalid_q;
  assign bfis_vertex_out       = vvalid_q ? mem_data_in : '0;
  assign bfis_query_out        = query_q;
  assign bfis_k_out            = k_q;
  assign res_valid_out         = (state == S_DONE);
  assign res_top_k_out         = res_q;
  assign busy_out              = (state != S_IDLE);

endmodule

// File: tb/tb_bfis_query_sequencer.sv
// tb/tb_bfis_query_sequencer.sv - directed self-checking bench for bfis_query_sequencer.
module tb_bfis_query_sequencer;

  localparam int DIM = 4, WIDTH = 16, PQ = 8, NV = 64, TMO = 16, AW = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [63:0]     req_query = '0;
  logic [3:0]      req_k = '0;
  logic [AW:0]     req_nverts = '0;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [63:0]     mem_data = '0;
  logic            bfis_rst;
  logic [63:0]     bfis_vertex;
  logic            bfis_vertex_valid;
  logic [63:0]     bfis_query;
  logic [3:0]      bfis_k;
  logic            bfis_valid = 1'b0;
  logic [127:0]    bfis_top_k = '0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [127:0]    res_top_k;
  logic            res_timeout;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  int rd_cnt, vv_cnt, clr_cnt, addr_err, vdata_err, lag_err, exp_addr, exp_vaddr;
  logic prev_rd;

  bfis_query_sequencer #(
    .DIM(DIM), .WIDTH(WIDTH), .PQ_LENGTH(PQ), .NUM_VERTICES(NV), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_query_in(req_query), .req_k_in(req_k), .req_nverts_in(req_nverts),
    .mem_rd_en_out(mem_rd_en), .mem_addr_out(mem_addr), .mem_data_in(mem_data),
    .bfis_rst_out(bfis_rst), .bfis_vertex_out(bfis_vertex),
    .bfis_vertex_valid_out(bfis_vertex_valid), .bfis_query_out(bfis_query),
    .bfis_k_out(bfis_k), .bfis_valid_in(bfis_valid), .bfis_top_k_in(bfis_top_k),
    .res_valid_out(res_valid), .res_ready_in(res_ready), .res_top_k_out(res_top_k),
    .res_timeout_out(res_timeout), .busy_out(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] vdata(input logic [AW-1:0] a);
    logic [15:0] w;
    w = {10'b0, a};
    return {w + 16'h4000, w + 16'h3000, w + 16'h2000, w + 16'h1000};
  endfunction

  // Registered vertex memory: data valid one cycle after the strobe.
  always @(posedge clk) mem_data <= mem_rd_en ? vdata(mem_addr) : '0;

  always @(negedge clk) begin
    if (mem_rd_en) begin
      if (mem_addr !== AW'(exp_addr)) addr_err++;
      exp_addr++;
      rd_cnt++;
    end
    if (bfis_vertex_valid) begin
      if (bfis_vertex !== vdata(AW'(exp_vaddr))) vdata_err++;
      exp_vaddr++;
      vv_cnt++;
    end
    if (bfis_vertex_valid !== prev_rd) lag_err++;
    prev_rd = mem_rd_en;
    if (bfis_rst) clr_cnt++;
  end

  task automatic clear_mon();
    rd_cnt = 0; vv_cnt = 0; clr_cnt = 0; addr_err = 0; vdata_err = 0;
    lag_err = 0; exp_addr = 0; exp_vaddr = 0; prev_rd = 1'b0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    clear_mon();
    #12;
    check("rst_ready", 128'(req_ready), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_res_valid", 128'(res_valid), 128'd0);
    check("rst_rd_en", 128'(mem_rd_en), 128'd0);
    check("rst_bfis_rst", 128'(bfis_rst), 128'd0);
    check("rst_top_k", res_top_k, 128'd0);
    check("rst_timeout", 128'(res_timeout), 128'd0);
    #5;
    rst = 1'b0;
    #1;
    check("idle_ready", 128'(req_ready), 128'd1);

    // nverts=5, k=4
    req_query = 64'h1111_2222_3333_4444; req_k = 4'd4; req_nverts = 7'd5; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("clear_pulse", 128'(bfis_rst), 128'd1);
    check("busy_ready", {busy, req_ready}, 128'b10);
    check("k_4", 128'(bfis_k), 128'd4);
    check("query_latch", 128'(bfis_query), 128'h1111_2222_3333_4444);
    tick();
    check("first_addr", {mem_rd_en, 1'b0, mem_addr}, {1'b1, 7'd0});
    tick(7);
    check("n5_clr_cnt", 128'(clr_cnt), 128'd1);
    check("n5_rd_cnt", 128'(rd_cnt), 128'd5);
    check("n5_vv_cnt", 128'(vv_cnt), 128'd5);
    check("n5_errs", 128'(addr_err + vdata_err + lag_err), 128'd0);
    check("n5_wait", {busy, res_valid}, 128'b10);

    // result held with res_ready low
    bfis_top_k = 128'h0003_0001_0007_0002; bfis_valid = 1'b1;
    tick();
    bfis_valid = 1'b0; bfis_top_k = 128'hdead_beef;
    for (int i = 0; i < 4; i++) begin
      check("held_valid", 128'(res_valid), 128'd1);
      check("held_top_k", res_top_k, 128'h0003_0001_0007_0002);
      if (i < 3) tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("back_idle", {res_valid, busy, req_ready}, 128'b001);
    bfis_valid = 1'b1;
    tick();
    bfis_valid = 1'b0;
    check("ignore_idle_valid", res_top_k, 128'h0003_0001_0007_0002);
    check("k_hold", 128'(bfis_k), 128'd4);

    // k=0, nverts=100 clamps
    clear_mon();
    req_k = 4'd0; req_nverts = 7'd100; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("k_0_to_1", 128'(bfis_k), 128'd1);
    tick(70);
    check("clamp_rd_cnt", 128'(rd_cnt), 128'd64);
    check("clamp_vv_cnt", 128'(vv_cnt), 128'd64);
    check("clamp_errs", 128'(addr_err + vdata_err + lag_err), 128'd0);
    bfis_top_k = 128'h55; bfis_valid = 1'b1; res_ready = 1'b1;
    tick();
    bfis_valid = 1'b0;
    check("fast_done_valid", {res_valid, 120'b0, res_top_k[7:0]}, {1'b1, 120'b0, 8'h55});
    tick();
    res_ready = 1'b0;
    check("fast_done_idle", {res_valid, req_ready}, 128'b01);

    // nverts=0, k=12
    clear_mon();
    req_k = 4'd12; req_nverts = 7'd0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("k_12_to_8", 128'(bfis_k), 128'd8);
    tick();
    check("n0_res_valid", 128'(res_valid), 128'd1);
    check("n0_top_k", res_top_k, 128'd0);
    check("n0_no_activity", 128'(rd_cnt + clr_cnt), 128'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // reset mid-stream at address 3 of 10
    req_k = 4'd3; req_nverts = 7'd10; req_query = 64'hABCD; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(4);
    check("pre_rst_addr", {mem_rd_en, 1'b0, mem_addr}, {1'b1, 7'd3});
    #1 rst = 1'b1;
    #1;
    check("async_rst_stream", {mem_rd_en, bfis_vertex_valid, busy, req_ready, bfis_rst}, 128'd0);
    check("async_rst_regs", {mem_addr, bfis_k, bfis_query}, 128'd0);
    clear_mon();
    #3 rst = 1'b0;
    req_nverts = 7'd3; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("first_edge_accept", 128'(bfis_rst), 128'd1);
    tick(5);
    check("restart_rd_cnt", 128'(rd_cnt), 128'd3);
    check("restart_errs", 128'(addr_err + vdata_err + lag_err), 128'd0);

`ifdef SEQ_WATCHDOG_EN
    tick(15);
    check("wd_not_yet", 128'(res_valid), 128'd0);
    tick();
    check("wd_fire", {res_valid, res_timeout}, 128'b11);
    check("wd_top_k", res_top_k, 128'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("wd_cleared", {res_valid, res_timeout}, 128'b00);
`else
    tick(40);
    check("no_wd_wait", {busy, res_valid, res_timeout}, 128'b100);
    bfis_top_k = 128'h77; bfis_valid = 1'b1;
    tick();
    bfis_valid = 1'b0;
    check("no_wd_done", {res_valid, res_timeout}, 128'b10);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
